// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - two-requester arbiter sharing one combinational 8-bit multiplier
//
// Each requester hands over an operand pair (reqN_valid/reqN_ready, reqN_a, reqN_b).
// The granted pair is held on the shared multiplier (mul_a, mul_b -> mul_product)
// for MUL_WAIT cycles, and the truncated product is then returned to the same
// requester (rspN_valid/rspN_ready, rspN_product). Only one transaction is in
// flight at a time. busy is high whenever the FSM is outside IDLE.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req{0,1}_valid/_ready/_a/_b  operand handshake per requester
//   rsp{0,1}_valid/_ready/_product  result handshake per requester
//   mul_a, mul_b, mul_product    shared multiplier interface
//   busy                         FSM not in IDLE
//
// Optional feature: define MUL_ARBITER_ROUND_ROBIN_EN to resolve simultaneous
// requests round-robin; otherwise requester 0 has fixed priority.
module mul_arbiter #(
    parameter int MUL_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_product,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_product,
    output logic [7:0] mul_a,
    output logic [7:0] mul_b,
    input  logic [7:0] mul_product,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    logic [7:0] op_a_q, op_b_q, res_q;
    logic       owner_q;
    logic       pick1;
    logic       hs;
    logic       rsp_done;

`ifdef MUL_ARBITER_ROUND_ROBIN_EN
    // Requester that won the most recent handshake; reset to 1 so 0 wins first.
    logic last_q;

    assign pick1 = req1_valid && (!req0_valid || !last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (hs) begin
            last_q <= req1_ready;
        end
    end
`else
    assign pick1 = req1_valid && !req0_valid;
`endif

    assign req0_ready = (state_q == IDLE) && req0_valid && !pick1;
    assign req1_ready = (state_q == IDLE) && pick1;
    assign hs         = req0_ready || req1_ready;

    assign rsp0_valid   = (state_q == RESP) && !owner_q;
    assign rsp1_valid   = (state_q == RESP) && owner_q;
    assign rsp0_product = rsp0_valid ? res_q : 8'h00;
    assign rsp1_product = rsp1_valid ? res_q : 8'h00;
    assign rsp_done     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign mul_a = (state_q == IDLE) ? 8'h00 : op_a_q;
    assign mul_b = (state_q == IDLE) ? 8'h00 : op_b_q;
    assign busy  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd1) state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_a_q  <= 8'h00;
            op_b_q  <= 8'h00;
            res_q   <= 8'h00;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        op_a_q  <= req1_ready ? req1_a : req0_a;
                        op_b_q  <= req1_ready ? req1_b : req0_b;
                        owner_q <= req1_ready;
                        cnt_q   <= 4'(MUL_WAIT);
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        res_q <= mul_product;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed self-checking bench for mul_arbiter
module tb_mul_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DUT with MUL_WAIT=1
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp0_product, rsp1_product;
    logic [7:0] mul_a, mul_b, mul_product;
    logic       busy;

    // DUT with MUL_WAIT=4 (only requester 0 used)
    logic       w_req0_valid, w_req0_ready, w_req1_ready;
    logic [7:0] w_req0_a, w_req0_b;
    logic       w_rsp0_valid, w_rsp0_ready, w_rsp1_valid;
    logic [7:0] w_rsp0_product, w_rsp1_product;
    logic [7:0] w_mul_a, w_mul_b, w_mul_product;
    logic       w_busy;

    assign mul_product   = 8'(mul_a * mul_b);
    assign w_mul_product = 8'(w_mul_a * w_mul_b);

    mul_arbiter #(.MUL_WAIT(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_product(rsp0_product),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_product(rsp1_product),
        .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product), .busy(busy)
    );

    mul_arbiter #(.MUL_WAIT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_a(w_req0_a), .req0_b(w_req0_b),
        .rsp0_valid(w_rsp0_valid), .rsp0_ready(w_rsp0_ready), .rsp0_product(w_rsp0_product),
        .req1_valid(1'b0), .req1_ready(w_req1_ready), .req1_a(8'h00), .req1_b(8'h00),
        .rsp1_valid(w_rsp1_valid), .rsp1_ready(1'b0), .rsp1_product(w_rsp1_product),
        .mul_a(w_mul_a), .mul_b(w_mul_b), .mul_product(w_mul_product), .busy(w_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        checks++;
        if ({mul_a, mul_b, rsp0_product, rsp1_product} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got=%h want=00000000", {mul_a, mul_b, rsp0_product, rsp1_product});
        end
        checks++;
        if ({w_busy, w_rsp0_valid, w_mul_a} !== 10'h0) begin
            errors++;
            $display("FAIL reset_dut4 got=%h want=000", {w_busy, w_rsp0_valid, w_mul_a});
        end
    endtask

    // Full transaction on requester n, response accepted immediately.
    task automatic do_txn(input bit n, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] want, input string name);
        int  k;
        bit  seen;
        if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        seen = 1'b0;
        for (k = 0; k < 20 && !seen; k++) begin
            if ((n ? req1_ready : req0_ready) === 1'b1) seen = 1'b1;
            else step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_grant got=timeout want=ready", name);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        seen = 1'b0;
        for (k = 0; k < 20 && !seen; k++) begin
            if ((rsp0_valid | rsp1_valid) === 1'b1) seen = 1'b1;
            else step();
        end
        checks++;
        if (!seen || (n ? rsp1_product : rsp0_product) !== want ||
            (n ? rsp0_valid : rsp1_valid) !== 1'b0) begin
            errors++;
            $display("FAIL %s_rsp got=%h/%b%b want=%h owner=%0d", name,
                     n ? rsp1_product : rsp0_product, rsp0_valid, rsp1_valid, want, n);
        end
        step();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_a = 8'd12; req0_b = 8'd11;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready got=%b%b want=10", req0_ready, req1_ready);
        end
        step();                                   // cycle 1 (BUSY)
        req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || rsp0_valid !== 1'b0 || mul_a !== 8'd12 || mul_b !== 8'd11) begin
            errors++;
            $display("FAIL single_busy got=busy%b v%b a%h b%h want=busy1 v0 a0c b0b",
                     busy, rsp0_valid, mul_a, mul_b);
        end
        step();                                   // cycle 2 (RESP)
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_product !== 8'h84 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp got=v%b p%h v1=%b want=v1 p84 v1=0",
                     rsp0_valid, rsp0_product, rsp1_valid);
        end
        rsp0_ready = 1'b1;
        step();                                   // cycle 3 (IDLE)
        rsp0_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || mul_a !== 8'h00) begin
            errors++;
            $display("FAIL single_idle got=busy%b v%b a%h want=busy0 v0 a00", busy, rsp0_valid, mul_a);
        end
    endtask

    task automatic test_truncation();
        do_txn(1'b1, 8'd20, 8'd13, 8'h04, "trunc_20x13");
        do_txn(1'b1, 8'd255, 8'd255, 8'h01, "trunc_255x255");
    endtask

    task automatic test_contention();
        bit         exp_g, g, seen;
        logic [7:0] exp_p;
        int         k;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4;
        req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd6;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
            exp_g = t[0];
`else
            exp_g = 1'b0;
`endif
            exp_p = exp_g ? 8'd30 : 8'd12;
            #1;
            seen = 1'b0;
            for (k = 0; k < 10 && !seen; k++) begin
                if ((req0_ready | req1_ready) === 1'b1) seen = 1'b1;
                else step();
            end
            g = req1_ready;
            checks++;
            if (!seen || g !== exp_g || (req0_ready & req1_ready) !== 1'b0) begin
                errors++;
                $display("FAIL contention_grant%0d got=%b%b want_owner=%0d", t, req0_ready, req1_ready, exp_g);
            end
            step();
            seen = 1'b0;
            for (k = 0; k < 10 && !seen; k++) begin
                if ((rsp0_valid | rsp1_valid) === 1'b1) seen = 1'b1;
                else step();
            end
            checks++;
            if (!seen || rsp1_valid !== exp_g || rsp0_valid !== !exp_g ||
                (exp_g ? rsp1_product : rsp0_product) !== exp_p) begin
                errors++;
                $display("FAIL contention_rsp%0d got=v%b%b p%h/%h want_owner=%0d p%h", t,
                         rsp0_valid, rsp1_valid, rsp0_product, rsp1_product, exp_g, exp_p);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd9;
        #1;
        step();                                   // handshake done, BUSY
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd3;
        step();                                   // RESP
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_product !== 8'h3f || busy !== 1'b1 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d got=v%b p%h busy%b r1%b want=v1 p3f busy1 r10",
                         c, rsp0_valid, rsp0_product, busy, req1_ready);
            end
            step();
        end
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release_ready got=%b want=0", req1_ready);
        end
        step();                                   // IDLE
        rsp0_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_idle got=busy%b r1%b v0%b want=busy0 r11 v00", busy, req1_ready, rsp0_valid);
        end
        do_txn(1'b1, 8'd2, 8'd3, 8'd6, "backpressure_req1");
    endtask

    task automatic test_wait4();
        w_req0_valid = 1'b1; w_req0_a = 8'd5; w_req0_b = 8'd7;
        #1;
        checks++;
        if (w_req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait4_ready got=%b want=1", w_req0_ready);
        end
        step();                                   // cycle 1
        w_req0_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (w_mul_a !== 8'd5 || w_mul_b !== 8'd7 || w_rsp0_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait4_cycle%0d got=a%h b%h v%b want=a05 b07 v0", c, w_mul_a, w_mul_b, w_rsp0_valid);
            end
            if (c < 4) step();
        end
        step();                                   // cycle 5
        checks++;
        if (w_rsp0_valid !== 1'b1 || w_rsp0_product !== 8'h23 || w_mul_a !== 8'd5 || w_mul_b !== 8'd7) begin
            errors++;
            $display("FAIL wait4_rsp got=v%b p%h a%h b%h want=v1 p23 a05 b07",
                     w_rsp0_valid, w_rsp0_product, w_mul_a, w_mul_b);
        end
        w_rsp0_ready = 1'b1;
        step();
        w_rsp0_ready = 1'b0;
        checks++;
        if (w_busy !== 1'b0 || w_rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait4_idle got=busy%b v%b want=busy0 v0", w_busy, w_rsp0_valid);
        end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd3;
        #1;
        step();                                   // BUSY
        req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy got=%b want=1", busy);
        end
        rsp0_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_idle%0d got=busy%b v%b%b want=busy0 v00", c, busy, rsp0_valid, rsp1_valid);
            end
            step();
        end
        do_txn(1'b0, 8'd4, 8'd4, 8'd16, "reset_mid_fresh");
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        w_req0_valid = 1'b0; w_req0_a = 8'h00; w_req0_b = 8'h00; w_rsp0_ready = 1'b0;

        test_reset();
        test_single();
        test_truncation();
        test_contention();
        test_backpressure();
        test_wait4();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter: MUL_WAIT, 1, number of cycles operands are held on the shared multiplier before the product is captured (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid  input  1; req0_ready  output  1; req0_a  input  8; req0_b  input  8. These form the requester 0 operand handshake.
REQ-005 SHALL have ports: rsp0_valid  output  1; rsp0_ready  input  1; rsp0_product  output  8. These form the requester 0 result handshake.
REQ-006 SHALL have ports req1_valid, req1_ready, req1_a, req1_b, rsp1_valid, rsp1_ready and rsp1_product, identical to REQ-004/005, for requester 1.
REQ-007 SHALL have ports: mul_a  output  8; mul_b  output  8. These are the operands driven to the shared combinational 8-bit multiplier.
REQ-008 SHALL have port: mul_product  input  8  low 8 bits of mul_a*mul_b from the shared multiplier.
REQ-009 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-011 SHALL, in IDLE, drive reqN_ready combinationally high only for the requester selected by the arbitration rule (REQ-020), and only while that requester's reqN_valid is high; all other ready outputs SHALL be 0.
REQ-012 SHALL, on a handshake (reqN_valid & reqN_ready), latch reqN_a/reqN_b into operand registers, record owner=N, load wait counter with MUL_WAIT, and enter BUSY.
REQ-013 SHALL drive mul_a/mul_b from the operand registers in BUSY and RESP, and drive 8'h00 in IDLE.
REQ-014 SHALL, in BUSY, decrement the counter each cycle; in the cycle the counter equals 1, it SHALL capture mul_product into the result register and enter RESP.
REQ-015 SHALL, in RESP, hold rspN_valid=1 for the owner only, with rspN_product = result register, stable until rspN_ready=1.
REQ-016 SHALL return to IDLE on the cycle after rspN_valid & rspN_ready, and SHALL NOT accept a new request in that same cycle.
REQ-017 SHALL meet this latency: handshake in cycle T, rsp valid first visible in cycle T+MUL_WAIT+1; minimum issue interval MUL_WAIT+2 cycles.
REQ-018 SHALL deassert all req*_ready in BUSY and RESP; requests arriving then wait and are not lost.
REQ-019 SHALL never assert rsp*_valid for the non-owner, and SHALL deliver results exactly once in handshake order.
REQ-020 SHALL use the following arbitration in IDLE: one valid requester is granted; with both valid, the rule in REQ-027/028 selects.
REQ-021 SHALL truncate results to 8 bits (product mod 256); no overflow flag.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, force state=IDLE, counter=0, operand/result registers=0, owner=0, and last-grant pointer=1.
REQ-023 SHALL hold all req*_ready, rsp*_valid and busy at 0, and rsp*_product, mul_a and mul_b at 8'h00, in the cycle after reset.
REQ-024 SHALL discard an in-flight transaction on reset during BUSY or RESP, with no response issued.

Configuration
REQ-025 SHALL recognise macro MUL_ARBITER_ROUND_ROBIN_EN.
REQ-026 SHALL update the last-grant pointer on every handshake.
REQ-027 SHALL, when the macro is defined, resolve simultaneous requests round-robin: grant the requester not granted last (after reset, requester 0 wins first).
REQ-028 SHALL, when the macro is undefined, use fixed priority: requester 0 always wins ties; the pointer logic SHALL be absent.

Verification
REQ-029 SHALL cover single request, MUL_WAIT=1: req0 a=12, b=11 handshake in cycle 0 -> rsp0_valid in cycle 2, rsp0_product=8'h84, rsp1_valid=0.
REQ-030 SHALL cover truncation: req1 a=20, b=13 -> rsp1_product=8'h04; a=255, b=255 -> 8'h01.
REQ-031 SHALL cover contention with the macro defined: both valid continuously (req0 3*4, req1 5*6) -> grants 0,1,0,1; products 12,30 alternate. With the macro undefined -> only req0 is granted while it stays valid.
REQ-032 SHALL cover backpressure: rsp0_ready held 0 for 5 cycles in RESP -> rsp0_valid and product stay stable, busy=1, req1_ready=0; release -> IDLE next cycle, req1 is then granted.
REQ-033 SHALL cover MUL_WAIT=4: handshake in cycle 0 -> rsp valid in cycle 5; mul_a/mul_b stable during cycles 1-5.
REQ-034 SHALL cover reset mid-operation: rst asserted in BUSY -> next cycle busy=0, no rsp*_valid; a fresh request then completes normally.
